// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage from NUM_REQ requesters.
// Optional burst lock is enabled by defining PIPE_ARB_LOCK_EN (adds the lock_in port).
module pipeline_rr_arbiter #(
    parameter int bus_width = 4,
    parameter int NUM_REQ   = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           valide_in,
    input  logic [NUM_REQ*bus_width-1:0] Datain,
    output logic [NUM_REQ-1:0]           ready_out,
    output logic                         valide_out,
    output logic [bus_width-1:0]         Dataout,
    output logic [ID_W-1:0]              grant_id,
    input  logic                         ready_in
`ifdef PIPE_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]           lock_in
`endif
);

    logic                 r_valid;
    logic [bus_width-1:0] r_data;
    logic [ID_W-1:0]      r_grant;
    logic [ID_W-1:0]      r_ptr;

    logic                 w_load;
    logic                 w_found;
    logic                 w_accept;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_ptrNext;

    assign w_load   = ~r_valid | ready_in;
    assign w_accept = w_load & w_found & ~rst;

    // Scan from the highest offset down so the requester nearest r_ptr is written last and wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valide_in[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        if (w_winner == ID_W'(NUM_REQ - 1)) begin
            w_ptrNext = '0;
        end else begin
            w_ptrNext = w_winner + ID_W'(1);
        end
`ifdef PIPE_ARB_LOCK_EN
        // A locked winner keeps top priority so its burst stays contiguous.
        if (lock_in[w_winner]) begin
            w_ptrNext = w_winner;
        end
`endif
    end

    always_comb begin
        ready_out = '0;
        if (w_accept) begin
            ready_out[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_data  <= Datain[w_winner*bus_width +: bus_width];
                r_grant <= w_winner;
                r_ptr   <= w_ptrNext;
            end
        end
    end

    assign valide_out = r_valid;
    assign Dataout    = r_data;
    assign grant_id   = r_grant;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Scoreboard bench for pipeline_rr_arbiter; the lock scenario runs only when PIPE_ARB_LOCK_EN is defined.
module tb_pipeline_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BW      = 4;
    localparam int ID_W    = 2;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     valide_in;
    logic [NUM_REQ*BW-1:0]  Datain;
    logic [NUM_REQ-1:0]     ready_out;
    logic                   valide_out;
    logic [BW-1:0]          Dataout;
    logic [ID_W-1:0]        grant_id;
    logic                   ready_in;
    logic [NUM_REQ-1:0]     lock_in;

    int checks = 0;
    int errors = 0;

    // Reference model state and the queue of beats accepted but not yet seen at the output.
    int                     mPtr;
    logic                   mValid;
    logic [BW-1:0]          mData;
    logic [ID_W-1:0]        mGrant;
    logic [ID_W+BW-1:0]     expQ[$];

    pipeline_rr_arbiter #(.bus_width(BW), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .valide_in  (valide_in),
        .Datain     (Datain),
        .ready_out  (ready_out),
        .valide_out (valide_out),
        .Dataout    (Dataout),
        .grant_id   (grant_id),
        .ready_in   (ready_in)
`ifdef PIPE_ARB_LOCK_EN
        ,
        .lock_in    (lock_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: predict ready_out, push the accepted beat, step, pop and compare the output stage.
    task automatic cycle();
        logic [NUM_REQ-1:0] expReady;
        logic [ID_W+BW-1:0] entry;
        logic               load;
        logic               found;
        logic               lockHit;
        int                 w;
        #1;
        load    = !mValid || ready_in;
        found   = 1'b0;
        lockHit = 1'b0;
        w       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valide_in[(mPtr + k) % NUM_REQ]) begin
                found = 1'b1;
                w     = (mPtr + k) % NUM_REQ;
            end
        end
`ifdef PIPE_ARB_LOCK_EN
        lockHit = lock_in[w];
`endif
        expReady = '0;
        if (!rst && load && found) begin
            expReady[w] = 1'b1;
            expQ.push_back({ID_W'(w), Datain[w*BW +: BW]});
        end
        checks++;
        if (ready_out !== expReady) begin
            errors++;
            $display("[TB] FAIL ready_out: got %b expected %b at %0t", ready_out, expReady, $time);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mValid = 1'b0;
            mData  = '0;
            mGrant = '0;
            mPtr   = 0;
            expQ.delete();
        end else if (load) begin
            mValid = found;
            if (found) begin
                entry  = expQ.pop_front();
                mGrant = entry[ID_W+BW-1:BW];
                mData  = entry[BW-1:0];
                mPtr   = lockHit ? w : (w + 1) % NUM_REQ;
            end
        end
        checks++;
        if (valide_out !== mValid || (mValid && (grant_id !== mGrant || Dataout !== mData))) begin
            errors++;
            $display("[TB] FAIL output_stage: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h",
                     valide_out, grant_id, Dataout, mValid, mGrant, mData);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valide_in = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (valide_out !== 1'b0 || Dataout !== '0 || grant_id !== '0 || ready_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b d=%h id=%0d rdy=%b expected 0/0/0/0",
                     valide_out, Dataout, grant_id, ready_out);
        end
    endtask

    task automatic test_full_contention();
        valide_in = 4'b1111;
        Datain    = {4'd4, 4'd3, 4'd2, 4'd1};
        ready_in  = 1'b1;
        checks++;
        if (valide_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL contention_prevalid: got %b expected 0", valide_out);
        end
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (valide_out !== 1'b1 || grant_id !== ID_W'(n % 4) || Dataout !== BW'(n % 4 + 1)) begin
                errors++;
                $display("[TB] FAIL contention_beat%0d: got v=%b id=%0d d=%0d expected v=1 id=%0d d=%0d",
                         n, valide_out, grant_id, Dataout, n % 4, n % 4 + 1);
            end
        end
        valide_in = '0;
        cycle();
    endtask

    task automatic test_backpressure();
        valide_in = 4'b0100;
        Datain    = {4'b0110, 4'b0101, 4'h0, 4'h0};
        ready_in  = 1'b1;
        cycle();
        valide_in = 4'b1000;
        ready_in  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (valide_out !== 1'b1 || Dataout !== 4'b0101 || ready_out !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall%0d: got v=%b d=%b rdy=%b expected v=1 d=0101 rdy=0000",
                         n, valide_out, Dataout, ready_out);
            end
        end
        ready_in = 1'b1;
        cycle();
        checks++;
        if (Dataout !== 4'b0110 || grant_id !== 2'd3) begin
            errors++;
            $display("[TB] FAIL stall_release: got d=%b id=%0d expected d=0110 id=3", Dataout, grant_id);
        end
        valide_in = '0;
        cycle();
    endtask

    task automatic test_wrap_skip();
        logic [ID_W-1:0] seq [3];
        seq[0] = 2'd3;
        seq[1] = 2'd1;
        seq[2] = 2'd2;
        valide_in = 4'b0100;
        Datain    = {4'hA, 4'hB, 4'h9, 4'hC};
        cycle();
        valide_in = 4'b1010;
        cycle();
        checks++;
        if (grant_id !== seq[0] || Dataout !== 4'hA) begin
            errors++;
            $display("[TB] FAIL wrap_first: got id=%0d d=%h expected id=3 d=a", grant_id, Dataout);
        end
        valide_in = 4'b0010;
        cycle();
        checks++;
        if (grant_id !== seq[1] || Dataout !== 4'h9) begin
            errors++;
            $display("[TB] FAIL skip_second: got id=%0d d=%h expected id=1 d=9", grant_id, Dataout);
        end
        valide_in = 4'b1111;
        cycle();
        checks++;
        if (grant_id !== seq[2]) begin
            errors++;
            $display("[TB] FAIL ptr_after_wrap: got id=%0d expected 2", grant_id);
        end
        valide_in = '0;
        cycle();
    endtask

    task automatic test_single_requester();
        valide_in = 4'b0001;
        Datain    = {4'h0, 4'h0, 4'h0, 4'h7};
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (valide_out !== 1'b1 || grant_id !== 2'd0 || Dataout !== 4'h7) begin
                errors++;
                $display("[TB] FAIL single%0d: got v=%b id=%0d d=%h expected v=1 id=0 d=7",
                         n, valide_out, grant_id, Dataout);
            end
        end
        valide_in = '0;
        cycle();
    endtask

    task automatic test_reset_mid();
        valide_in = 4'b0100;
        Datain    = {4'h1, 4'hE, 4'h2, 4'hD};
        cycle();
        valide_in = 4'b0101;
        rst = 1'b1;
        cycle();
        checks++;
        if (valide_out !== 1'b0 || dut.r_ptr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got v=%b ptr=%0d expected v=0 ptr=0", valide_out, dut.r_ptr);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (grant_id !== 2'd0 || Dataout !== 4'hD) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got id=%0d d=%h expected id=0 d=d", grant_id, Dataout);
        end
        valide_in = '0;
        cycle();
    endtask

`ifdef PIPE_ARB_LOCK_EN
    task automatic test_lock();
        logic [ID_W-1:0] expId [4];
        expId[0] = 2'd1;
        expId[1] = 2'd1;
        expId[2] = 2'd1;
        expId[3] = 2'd2;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        valide_in = 4'b0110;
        Datain    = {4'h0, 4'h5, 4'h3, 4'h0};
        for (int n = 0; n < 4; n++) begin
            lock_in = (n < 2) ? 4'b0010 : 4'b0000;
            cycle();
            checks++;
            if (grant_id !== expId[n]) begin
                errors++;
                $display("[TB] FAIL lock_beat%0d: got id=%0d expected %0d", n, grant_id, expId[n]);
            end
        end
        lock_in   = '0;
        valide_in = '0;
        cycle();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        valide_in = '0;
        Datain    = '0;
        ready_in  = 1'b1;
        lock_in   = '0;
        mPtr      = 0;
        mValid    = 1'b0;
        mData     = '0;
        mGrant    = '0;
        test_reset();
        test_full_contention();
        test_backpressure();
        test_wrap_skip();
        test_single_requester();
        test_reset_mid();
`ifdef PIPE_ARB_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
